// File: rtl/fp_add_pipe.sv
// Three-stage floating-point adder/subtractor with round-to-nearest-even, flushed denormals
// and a valid/ready stream interface: align -> add -> normalize/round.
module fp_add_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic                 sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic                 ovf
);
    localparam int W      = 1 + EXP_W + MAN_W;
    localparam int SW     = MAN_W + 4;          // hidden, mantissa, G, R, S
    localparam int EW     = EXP_W + 2;          // signed working exponent
    localparam int LZW    = $clog2(SW + 1);
    localparam int STAGES = 3;
    localparam logic [EXP_W-1:0] EMAX = '1;
    localparam logic [W-1:0]     QNAN = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

    typedef struct packed {
        logic             s;
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m;
    } fp_t;

    function automatic logic [LZW-1:0] lzc(input logic [SW-1:0] v);
        logic [LZW-1:0] n;
        n = '0;
        for (int i = 0; i < SW; i++)
            if (v[i]) n = LZW'(SW - 1 - i);
        return n;
    endfunction

    logic              advance;
    logic [STAGES:1]   vld_pipe;

    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_pipe[STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_pipe <= '0;
        else if (advance) vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
    end

    // ---------------- S1: unpack, specials, swap, align ----------------
    fp_t              ua, ub, ux, uy;
    logic             a_nan, b_nan, a_inf, b_inf, spec_c;
    logic [W-1:0]     sval_c;
    logic [EXP_W-1:0] d;
    logic [SW-1:0]    x_sig, y_raw, y_al;
    logic [2*SW-1:0]  y_ext;

    always_comb begin
        ua    = a;
        ub    = b;
        ub.s  = b[W-1] ^ sub;
        a_nan = (ua.e == EMAX) && (ua.m != '0);
        b_nan = (ub.e == EMAX) && (ub.m != '0);
        a_inf = (ua.e == EMAX) && (ua.m == '0);
        b_inf = (ub.e == EMAX) && (ub.m == '0);
        spec_c = (ua.e == EMAX) || (ub.e == EMAX);
        if (a_nan || b_nan || (a_inf && b_inf && (ua.s != ub.s)))
            sval_c = QNAN;
        else if (a_inf)
            sval_c = {ua.s, EMAX, {MAN_W{1'b0}}};
        else
            sval_c = {ub.s, EMAX, {MAN_W{1'b0}}};
        // denormals become signed zeros before the magnitude compare
        if (ua.e == '0) ua.m = '0;
        if (ub.e == '0) ub.m = '0;
        if ({ub.e, ub.m} > {ua.e, ua.m}) begin
            ux = ub;
            uy = ua;
        end else begin
            ux = ua;
            uy = ub;
        end
        d     = ux.e - uy.e;
        x_sig = {ux.e != '0, ux.m, 3'b000};
        y_raw = {uy.e != '0, uy.m, 3'b000};
        y_ext = {y_raw, {SW{1'b0}}} >> d;
        if (d >= EXP_W'(SW))
            y_al = {{(SW-1){1'b0}}, |y_raw};
        else
            y_al = {y_ext[2*SW-1:SW+1], y_ext[SW] | (|y_ext[SW-1:0])};
    end

    logic             s1_spec, s1_sx, s1_sy;
    logic [W-1:0]     s1_sval;
    logic [EXP_W-1:0] s1_ex;
    logic [SW-1:0]    s1_xs, s1_ys;

    always_ff @(posedge clk) begin
        if (advance && in_valid) begin
            s1_spec <= spec_c;
            s1_sval <= sval_c;
            s1_sx   <= ux.s;
            s1_sy   <= uy.s;
            s1_ex   <= ux.e;
            s1_xs   <= x_sig;
            s1_ys   <= y_al;
        end
    end

    // ---------------- S2: signed magnitude add ----------------
    logic [SW:0] sum_c;

    always_comb begin
        if (s1_sx ^ s1_sy) sum_c = {1'b0, s1_xs} - {1'b0, s1_ys};
        else               sum_c = {1'b0, s1_xs} + {1'b0, s1_ys};
    end

    logic             s2_spec, s2_sign, s2_zneg;
    logic [W-1:0]     s2_sval;
    logic [EXP_W-1:0] s2_ex;
    logic [SW:0]      s2_sum;

    always_ff @(posedge clk) begin
        if (advance && vld_pipe[1]) begin
            s2_spec <= s1_spec;
            s2_sval <= s1_sval;
            s2_sign <= s1_sx;
            s2_zneg <= s1_sx & s1_sy;   // only (-0)+(-0) keeps a negative exact zero
            s2_ex   <= s1_ex;
            s2_sum  <= sum_c;
        end
    end

    // ---------------- S3: normalize, round, pack ----------------
    logic [LZW-1:0]       lz;
    logic [SW-1:0]        nm;
    logic signed [EW-1:0] e_n, e_r;
    logic                 rinc;
    logic [MAN_W+1:0]     mr;
    logic [MAN_W-1:0]     man_o;
    logic [W-1:0]         res_c;
    logic                 ovf_c;

    always_comb begin
        lz = lzc(s2_sum[SW-1:0]);
        if (s2_sum[SW]) begin
            nm  = {s2_sum[SW:2], s2_sum[1] | s2_sum[0]};
            e_n = $signed({2'b00, s2_ex}) + EW'(1);
        end else begin
            nm  = s2_sum[SW-1:0] << lz;
            e_n = $signed({2'b00, s2_ex}) - $signed({{(EW-LZW){1'b0}}, lz});
        end
        rinc = nm[2] & (nm[1] | nm[0] | nm[3]);
        mr   = {1'b0, nm[SW-1:3]} + (MAN_W+2)'(rinc);
        if (mr[MAN_W+1]) begin
            e_r   = e_n + EW'(1);
            man_o = mr[MAN_W:1];
        end else begin
            e_r   = e_n;
            man_o = mr[MAN_W-1:0];
        end
        ovf_c = 1'b0;
        if (s2_spec)
            res_c = s2_sval;
        else if (s2_sum == '0)
            res_c = {s2_zneg, {(W-1){1'b0}}};
        else if (e_n[EW-1] || e_n == '0)
            res_c = {s2_sign, {(W-1){1'b0}}};
        else if (e_r >= $signed({2'b00, EMAX})) begin
            res_c = {s2_sign, EMAX, {MAN_W{1'b0}}};
            ovf_c = 1'b1;
        end else
            res_c = {s2_sign, e_r[EXP_W-1:0], man_o};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= '0;
            ovf    <= 1'b0;
        end else if (advance && vld_pipe[STAGES-1]) begin
            result <= res_c;
            ovf    <= ovf_c;
        end
    end

endmodule

// File: tb/tb_fp_add_pipe.sv
// Bench for fp_add_pipe: exact-integer reference model, scoreboard compare on every output
// transfer, directed vectors pinning the model, stall and mid-stream reset scenarios.
module tb_fp_add_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid, in_ready, sub, out_valid, out_ready, ovf;
    logic [31:0] a, b, result;

    fp_add_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        int          cyc;
    } exp_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] r;
        logic        o;
    } vec_t;

    exp_t        sb_q[$];
    vec_t        vecs[18];
    int          n_chk = 0, n_pass = 0, cyc = 0, n_out = 0, n_stall = 0;
    bit          lat_en = 0, prev_stall = 0;
    logic [31:0] prev_res;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, want);
    endtask

    // Exact sum as a wide integer in units of 2^-149, then RNE to 24 significant bits.
    function automatic exp_t model(input logic [31:0] fa, input logic [31:0] fb, input logic fs);
        exp_t         r;
        logic         sa, sbb, sgn;
        int           ea, eb, p, sh, e;
        logic [22:0]  ma, mb;
        logic [299:0] ua, ub, mag, one, rem, half;
        logic [24:0]  mant;
        r.ovf = 1'b0;
        r.cyc = 0;
        sa = fa[31]; ea = int'(fa[30:23]); ma = fa[22:0];
        sbb = fb[31] ^ fs; eb = int'(fb[30:23]); mb = fb[22:0];
        if ((ea == 255 && ma != 0) || (eb == 255 && mb != 0) || (ea == 255 && eb == 255 && sa != sbb)) begin
            r.res = 32'h7FC00000;
            return r;
        end
        if (ea == 255) begin r.res = {sa, 8'hFF, 23'h0}; return r; end
        if (eb == 255) begin r.res = {sbb, 8'hFF, 23'h0}; return r; end
        one = 1;
        ua = (ea == 0) ? '0 : ({276'b0, 1'b1, ma} << (ea - 1));
        ub = (eb == 0) ? '0 : ({276'b0, 1'b1, mb} << (eb - 1));
        if (sa == sbb) begin mag = ua + ub; sgn = sa; end
        else if (ua >= ub) begin mag = ua - ub; sgn = sa; end
        else begin mag = ub - ua; sgn = sbb; end
        if (mag == 0) begin r.res = {sa & sbb, 31'h0}; return r; end
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        e = p - 22;
        if (e <= 0) begin r.res = {sgn, 31'h0}; return r; end
        sh = p - 23;
        mant = 25'(mag >> sh);
        rem = mag & ((one << sh) - one);
        if (sh > 0) begin
            half = one << (sh - 1);
            if (rem > half || (rem == half && mant[0])) mant++;
        end
        if (mant[24]) begin mant = mant >> 1; e++; end
        if (e >= 255) begin r.res = {sgn, 8'hFF, 23'h0}; r.ovf = 1'b1; return r; end
        r.res = {sgn, 8'(e), mant[22:0]};
        return r;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        cyc++;
        if (rst) prev_stall = 0;
        else begin
            if (in_valid && in_ready) begin
                e = model(a, b, sub);
                e.cyc = cyc;
                sb_q.push_back(e);
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_output: got %h expected no result", result);
                end else begin
                    e = sb_q.pop_front();
                    check("result", result, e.res);
                    check("ovf", 32'(ovf), 32'(e.ovf));
                    if (lat_en) check("latency", 32'(cyc - e.cyc), 32'd3);
                    n_out++;
                end
            end
            if (prev_stall && out_valid) check("hold_result", result, prev_res);
            if (out_valid && !out_ready) begin
                check("in_ready_stall", 32'(in_ready), 32'd0);
                n_stall++;
            end
            prev_stall = out_valid && !out_ready;
            prev_res   = result;
        end
    end

    task automatic send(input logic [31:0] va, input logic [31:0] vb, input logic vs);
        bit acc = 0;
        in_valid = 1'b1; a = va; b = vb; sub = vs;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            n_chk++;
            $display("FAIL send_timeout: in_ready got 0 expected 1");
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && sb_q.size() != 0; k++) @(posedge clk);
        #1;
        check("drain_empty", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        exp_t m;
        int   n0;
        vecs[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0};
        vecs[1]  = '{32'h3FC00000, 32'h3F000000, 1'b1, 32'h3F800000, 1'b0};
        vecs[2]  = '{32'h3FC00000, 32'hBF000000, 1'b0, 32'h3F800000, 1'b0};
        vecs[3]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0};
        vecs[4]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b0};
        vecs[5]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0};
        vecs[6]  = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 1'b0};
        vecs[7]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1};
        vecs[8]  = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 1'b0};
        vecs[9]  = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0};
        vecs[10] = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 1'b0};
        vecs[11] = '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0};
        vecs[12] = '{32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 1'b0};
        vecs[13] = '{32'h3F800000, 32'h00000005, 1'b0, 32'h3F800000, 1'b0};
        vecs[14] = '{32'h4B800000, 32'h3F800000, 1'b0, 32'h4B800000, 1'b0};
        vecs[15] = '{32'h4B800001, 32'h3F800000, 1'b0, 32'h4B800002, 1'b0};
        vecs[16] = '{32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF, 1'b0};
        vecs[17] = '{32'hFF800000, 32'hFF800000, 1'b1, 32'h7FC00000, 1'b0};

        in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // directed vectors, one result per cycle, fixed 3-cycle latency
        lat_en = 1;
        foreach (vecs[i]) begin
            m = model(vecs[i].a, vecs[i].b, vecs[i].s);
            check("model_pin", m.res, vecs[i].r);
            check("model_pin_ovf", 32'(m.ovf), 32'(vecs[i].o));
            send(vecs[i].a, vecs[i].b, vecs[i].s);
        end
        in_valid = 1'b0;
        drain();

        for (int i = 0; i < 24; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)));
        in_valid = 1'b0;
        drain();
        lat_en = 0;

        // back-to-back stream with a 5-cycle downstream stall in the middle
        n0 = n_out;
        n_stall = 0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(32'h3F800000 + 32'(i * 3), 32'h40000000 + 32'(i << 18), 1'(i % 2));
                in_valid = 1'b0;
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check("stream_count", 32'(n_out - n0), 32'd8);
        check("stall_seen", 32'(n_stall >= 4), 32'd1);

        // fill the pipe against a stalled sink, then reset mid-cycle
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(32'h3F800000, 32'h3F800000 + 32'(i), 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_result", result, 32'd0);
        sb_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        send(32'h3F800000, 32'h3F800000, 1'b0);
        in_valid = 1'b0;
        drain();
        check("post_rst_out_count", 32'(n_out - n0), 32'd9);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
